// File: rtl/param_sort.sv
// Parameterised in-place bubble sorter over a small register array.
// Data is loaded word by word while idle. A start pulse sorts the array in
// place, ascending or descending, using a signed or unsigned compare.
// A browse pointer gives a combinational view of any word, in any state.
module param_sort #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              up,
  input  logic              sgn,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              prior,
  input  logic              next,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycles,
  output logic [ADDR_W-1:0] view_addr,
  output logic [DATA_W-1:0] view_data
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LIM_INIT = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_SWAP,
    S_PASS_END
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [ADDR_W-1:0] view_q, view_d;
  logic              swapped_q, swapped_d;
  logic              up_q, up_d;
  logic              sgn_q, sgn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       cycles_q, cycles_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] i_nxt;
  logic [ADDR_W-1:0] lim_last;
  logic [DATA_W-1:0] word_a;
  logic [DATA_W-1:0] word_b;
  logic              a_gt_b;
  logic              a_lt_b;
  logic              out_of_order;
  logic              accept_start;

  // Compare the pair under the cursor; equal words always count as in order.
  always_comb begin
    i_nxt    = i_q + ONE;
    lim_last = lim_q - ONE;
    word_a   = mem_q[i_q];
    word_b   = mem_q[i_nxt];
    if (sgn_q) begin
      a_gt_b = $signed(word_a) > $signed(word_b);
      a_lt_b = $signed(word_a) < $signed(word_b);
    end else begin
      a_gt_b = word_a > word_b;
      a_lt_b = word_a < word_b;
    end
    out_of_order = up_q ? a_gt_b : a_lt_b;
    accept_start = (state_q == S_IDLE) && start;
  end

  // Sequencer next state: walk pairs, shrink the window each pass, stop early when a pass made no swap.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    lim_d     = lim_q;
    swapped_d = swapped_q;
    up_d      = up_q;
    sgn_d     = sgn_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cycles_d  = cycles_q;
    if (state_q != S_IDLE && cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          up_d      = up;
          sgn_d     = sgn;
          i_d       = '0;
          lim_d     = LIM_INIT;
          swapped_d = 1'b0;
          cycles_d  = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_CMP;
        end
      end
      S_CMP: begin
        if (out_of_order) begin
          state_d = S_SWAP;
        end else if (i_q == lim_last) begin
          state_d = S_PASS_END;
        end else begin
          i_d = i_nxt;
        end
      end
      S_SWAP: begin
        swapped_d = 1'b1;
        if (i_q == lim_last) begin
          state_d = S_PASS_END;
        end else begin
          i_d     = i_nxt;
          state_d = S_CMP;
        end
      end
      default: begin
        if (!swapped_q || lim_q == ONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          lim_d     = lim_last;
          i_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_CMP;
        end
      end
    endcase
  end

  // Browse pointer: accepted start rewinds, both buttons hold, otherwise step with wrap.
  always_comb begin
    view_d = view_q;
    if (accept_start) begin
      view_d = '0;
    end else if (prior && next) begin
      view_d = view_q;
    end else if (prior) begin
      view_d = view_q - ONE;
    end else if (next) begin
      view_d = view_q + ONE;
    end
  end

  // Control and status registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      lim_q     <= LIM_INIT;
      swapped_q <= 1'b0;
      up_q      <= 1'b0;
      sgn_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cycles_q  <= '0;
      view_q    <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      lim_q     <= lim_d;
      swapped_q <= swapped_d;
      up_q      <= up_d;
      sgn_q     <= sgn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cycles_q  <= cycles_d;
      view_q    <= view_d;
    end
  end

  // Storage: swap writes both words at once; loads only while idle. Contents survive reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state_q == S_SWAP) begin
        mem_q[i_q]   <= word_b;
        mem_q[i_nxt] <= word_a;
      end else if (state_q == S_IDLE && ld_we) begin
        mem_q[ld_addr] <= ld_data;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cycles    = cycles_q;
  assign view_addr = view_q;
  assign view_data = mem_q[view_q];

endmodule

// File: tb/tb_param_sort.sv
// Randomised self-checking bench for param_sort (ADDR_W=2, DATA_W=8).
// Expected order and cycle count come from a plain bubble-sort model
// that charges one cycle per compare, per swap and per pass end.
`timescale 1ns/1ps
module tb_param_sort;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rstn, start, up, sgn, ld_we, prior, next;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          busy, done;
  logic [31:0]   cycles;
  logic [AW-1:0] view_addr;
  logic [DW-1:0] view_data;

  int n_checks = 0;
  int n_errors = 0;
  int vp = 0;

  logic [DW-1:0] src     [N];
  logic [DW-1:0] exp_mem [N];
  int            exp_cyc;

  param_sort #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .up(up), .sgn(sgn),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .prior(prior), .next(next), .busy(busy), .done(done),
    .cycles(cycles), .view_addr(view_addr), .view_data(view_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit wrong_order(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input bit asc, input bit signed_cmp);
    int va, vb;
    va = signed_cmp ? int'($signed(a)) : int'(a);
    vb = signed_cmp ? int'($signed(b)) : int'(b);
    return asc ? (va > vb) : (va < vb);
  endfunction

  // Bubble sort on exp_mem, counting cycles as compares + swaps + one per pass.
  task automatic model_sort(input bit asc, input bit signed_cmp);
    int lim;
    bit sw;
    logic [DW-1:0] t;
    lim = N - 1;
    exp_cyc = 0;
    forever begin
      sw = 0;
      for (int k = 0; k < lim; k++) begin
        exp_cyc++;
        if (wrong_order(exp_mem[k], exp_mem[k+1], asc, signed_cmp)) begin
          t = exp_mem[k]; exp_mem[k] = exp_mem[k+1]; exp_mem[k+1] = t;
          exp_cyc++;
          sw = 1;
        end
      end
      exp_cyc++;
      if (!sw || lim == 1) break;
      lim--;
    end
  endtask

  // Walk the whole array with next and compare each word against exp_mem.
  task automatic read_back(input string tag);
    for (int k = 0; k < N; k++) begin
      check_val({tag, "_vaddr"}, 32'(view_addr), 32'(vp));
      check_val({tag, "_data"}, 32'(view_data), 32'(exp_mem[vp]));
      next = 1'b1; tick(); next = 1'b0;
      vp = (vp + 1) % N;
    end
  endtask

  task automatic do_sort(input string tag, input bit load, input bit asc, input bit signed_cmp,
                         input bit wr_at_start, input bit poke_busy, input bit chk_cyc);
    int n;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        ld_we = 1'b1; ld_addr = AW'(k); ld_data = src[k];
        tick();
      end
      ld_we = 1'b0;
    end
    if (wr_at_start) begin
      src[3] = DW'($urandom);
      ld_we = 1'b1; ld_addr = 2'd3; ld_data = src[3];
    end
    for (int k = 0; k < N; k++) exp_mem[k] = src[k];
    model_sort(asc, signed_cmp);
    start = 1'b1; up = asc; sgn = signed_cmp;
    tick();
    start = 1'b0; ld_we = 1'b0;
    vp = 0;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    if (poke_busy) begin
      ld_we = 1'b1; ld_addr = 2'd0; ld_data = ~src[0];
      start = 1'b1; up = ~asc; sgn = ~signed_cmp;
      tick(); n++;
      ld_we = 1'b0; start = 1'b0;
    end
    while (busy && n < 300) begin
      tick(); n++;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    if (chk_cyc) begin
      check_val({tag, "_cycles"}, cycles, 32'(exp_cyc));
      check_val({tag, "_busy_len"}, 32'(n), 32'(exp_cyc));
    end
    $display("sort %s up=%0d sgn=%0d cycles=%0d expected=%0d", tag, asc, signed_cmp, cycles, exp_cyc);
    read_back(tag);
  endtask

  task automatic set_src(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    src[0] = a; src[1] = b; src[2] = c; src[3] = d;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; up = 1'b1; sgn = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_data = '0; prior = 1'b0; next = 1'b0;
    tick(); tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_cycles", cycles, 32'd0);
    check_val("rst_vaddr", 32'(view_addr), 32'd0);
    rstn = 1'b1;
    vp = 0;

    // Directed vectors
    set_src(8'd1, 8'd2, 8'd3, 8'd4);
    do_sort("sorted", 1, 1, 0, 0, 0, 1);
    check_val("sorted_cyc4", cycles, 32'd4);
    set_src(8'd4, 8'd3, 8'd2, 8'd1);
    do_sort("reverse", 1, 1, 0, 0, 0, 1);
    check_val("reverse_cyc15", cycles, 32'd15);
    set_src(8'h80, 8'h01, 8'hFF, 8'h00);
    do_sort("signed", 1, 1, 1, 0, 0, 1);
    set_src(8'h80, 8'h01, 8'hFF, 8'h00);
    do_sort("unsigned", 1, 1, 0, 0, 0, 1);
    set_src(8'd2, 8'd2, 8'd5, 8'd1);
    do_sort("desc_eq", 1, 0, 0, 0, 0, 1);

    // Browse controls
    rstn = 1'b0; tick(); rstn = 1'b1; vp = 0;
    prior = 1'b1; tick(); prior = 1'b0;
    check_val("br_prior", 32'(view_addr), 32'd3);
    next = 1'b1; tick(); next = 1'b0;
    check_val("br_next", 32'(view_addr), 32'd0);
    next = 1'b1; tick(); next = 1'b0;
    prior = 1'b1; next = 1'b1; tick(); prior = 1'b0; next = 1'b0;
    check_val("br_hold", 32'(view_addr), 32'd1);
    start = 1'b1; up = 1'b1; sgn = 1'b0; tick(); start = 1'b0;
    check_val("br_start", 32'(view_addr), 32'd0);
    for (int k = 0; k < 40 && busy; k++) tick();

    // Reset during the second pass, with start/ld_we/next asserted alongside it
    set_src(8'd4, 8'd3, 8'd2, 8'd1);
    for (int k = 0; k < N; k++) begin
      ld_we = 1'b1; ld_addr = AW'(k); ld_data = src[k]; tick();
    end
    ld_we = 1'b0;
    start = 1'b1; up = 1'b1; sgn = 1'b0; tick(); start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rstn = 1'b0; start = 1'b1; ld_we = 1'b1; ld_addr = 2'd0; ld_data = 8'h99; next = 1'b1;
    tick();
    rstn = 1'b1; start = 1'b0; ld_we = 1'b0; next = 1'b0; vp = 0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_cycles", cycles, 32'd0);
    check_val("abort_vaddr", 32'(view_addr), 32'd0);
    do_sort("resort", 0, 1, 0, 0, 0, 0);

    // Writes and starts while busy are ignored; write on start cycle is seen
    set_src(8'd9, 8'd7, 8'd8, 8'd6);
    do_sort("busy_poke", 1, 1, 0, 0, 1, 1);
    set_src(8'd3, 8'd1, 8'd2, 8'd0);
    do_sort("wr_start", 1, 0, 1, 1, 0, 1);

    // Random arrays, sometimes from a narrow range to force duplicates
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < N; k++)
        src[k] = (r % 3 == 0) ? DW'($urandom_range(0, 2)) : DW'($urandom);
      do_sort($sformatf("rnd%0d", r), 1, 1'($urandom), 1'($urandom),
              (r % 5 == 4), (r % 7 == 3), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_sort.md
PARAM_SORT -- requirements
Module: param_sort

Interface
REQ-001 Parameter DATA_W, default 32, element width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W, ADDR_W >= 1.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rstn  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a sort from IDLE.
REQ-006 up  in  1  1 = ascending, 0 = descending; sampled at accepted start.
REQ-007 sgn  in  1  1 = two's-complement compare, 0 = unsigned; sampled at accepted start.
REQ-008 ld_we  in  1  load-write enable, honoured only when busy=0.
REQ-009 ld_addr  in  ADDR_W  load address.
REQ-010 ld_data  in  DATA_W  load data.
REQ-011 prior  in  1  decrement browse pointer.
REQ-012 next  in  1  increment browse pointer.
REQ-013 busy  out  1  sort in progress.
REQ-014 done  out  1  last sort finished; sticky.
REQ-015 cycles  out  32  clock cycles spent busy in last/current sort.
REQ-016 view_addr  out  ADDR_W  browse pointer.
REQ-017 view_data  out  DATA_W  mem[view_addr], combinational read.

Function
REQ-018 Storage: DEPTH x DATA_W register array, two combinational read ports, one-cycle dual-word write for swap.
REQ-019 States: IDLE, CMP, SWAP, PASS_END; internal i (ADDR_W), lim (ADDR_W), swapped flag, latched up_r/sgn_r.
REQ-020 IDLE + start: latch up/sgn, i=0, lim=DEPTH-1, swapped=0, cycles=0, done=0, busy=1, go CMP.
REQ-021 CMP: compare a=mem[i], b=mem[i+1]; out-of-order means a>b if up_r, a<b if !up_r, per sgn_r; equal is in-order.
REQ-022 CMP out-of-order -> SWAP; in-order and i==lim-1 -> PASS_END; else i=i+1, stay CMP.
REQ-023 SWAP: mem[i]<=b, mem[i+1]<=a, swapped=1; i==lim-1 -> PASS_END; else i=i+1 -> CMP.
REQ-024 PASS_END: if swapped==0 or lim==1 -> IDLE, busy=0, done=1; else lim=lim-1, i=0, swapped=0 -> CMP.
REQ-025 cycles increments by 1 every cycle busy=1 (CMP, SWAP, PASS_END); holds in IDLE; saturates at 2**32-1.
REQ-026 Latency: already-ordered input finishes in DEPTH busy cycles; each swap adds one cycle.
REQ-027 start while busy=1 ignored; ld_we while busy=1 ignored; up/sgn changes while busy ignored.
REQ-028 ld_we in IDLE writes mem[ld_addr]<=ld_data next edge; simultaneous start and ld_we: write performed, sort begins same edge, sort sees written value from the following cycle onward.
REQ-029 Browse priority: start (sets view_addr=0) > prior&next both (hold) > prior (view_addr-1) > next (view_addr+1); wrap modulo DEPTH; browse active in any state.
REQ-030 view_data reflects mem content including swaps in progress.

Reset
REQ-031 rstn=0 at edge: state IDLE, busy=0, done=0, cycles=0, view_addr=0, i=0, lim=DEPTH-1, swapped=0.
REQ-032 Memory contents are not reset; reset mid-sort aborts, leaving partially sorted data.
REQ-033 Reset dominates start, ld_we, prior, next in the same cycle.

Verification (ADDR_W=2, DATA_W=8)
REQ-034 Load {1,2,3,4}, start up=1 sgn=0 -> busy 4 cycles, done=1, cycles=4, mem unchanged.
REQ-035 Load {4,3,2,1}, start up=1 -> done=1, cycles=15, mem={1,2,3,4}.
REQ-036 Load {0x80,0x01,0xFF,0x00}, up=1 sgn=1 -> {0x80,0xFF,0x00,0x01}; sgn=0 -> {0x00,0x01,0x80,0xFF}.
REQ-037 Load {2,2,5,1}, up=0 -> {5,2,2,1}; equal elements never swapped.
REQ-038 view_addr=0, prior -> 3; next -> 0; prior&next -> hold; start -> 0.
REQ-039 rstn=0 during second pass -> busy=0, done=0, cycles=0; start again -> correctly sorted; ld_we during busy -> no memory change.
